// File: rtl/decode_stage.sv
// Instruction-decode stage: 32x32 register file with write-through bypass, instruction decode,
// load-use hazard detection and the ID/EX pipeline register feeding the execute stage.
module decode_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_instr,
  input  logic [31:0] if_pc,
  input  logic        if_valid,
  input  logic        pcsrc,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        id_stall,
  output logic [31:0] ex_read_reg1,
  output logic [31:0] ex_read_reg2,
  output logic [31:0] ex_dest_reg,
  output logic [31:0] ex_imm,
  output logic [31:0] ex_pc,
  output logic        ex_alu_src,
  output logic [2:0]  ex_alu_ctrl,
  output logic        ex_branch,
  output logic        ex_mac,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_reg_write,
  output logic [4:0]  ex_wr_addr,
  output logic        ex_valid
);

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpMac   = 6'b011100;

  typedef struct packed {
    logic        valid;
    logic [31:0] read_reg1;
    logic [31:0] read_reg2;
    logic [31:0] dest_reg;
    logic [31:0] imm;
    logic [31:0] pc;
    logic        alu_src;
    logic [2:0]  alu_ctrl;
    logic        branch;
    logic        mac;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic [4:0]  wr_addr;
  } idex_t;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] rf_q [32];
  logic [31:0] rs_val, rt_val, rd_val;
  logic        wb_fwd;
  logic        dec_ok, use_rs, use_rt, use_rd;
  logic        ld_pending, hazard;
  idex_t       dec, idex_d, idex_q;

  assign op    = if_instr[31:26];
  assign rs    = if_instr[25:21];
  assign rt    = if_instr[20:16];
  assign rd    = if_instr[15:11];
  assign funct = if_instr[5:0];

  // Shift amount field is not part of this ISA subset.
  logic unused_shamt;
  assign unused_shamt = ^if_instr[10:6];

  assign wb_fwd = wb_we & (wb_addr != 5'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (wb_fwd) begin
      rf_q[wb_addr] <= wb_data;
    end
  end

  assign rs_val = (rs == 5'd0) ? '0 : (wb_fwd && wb_addr == rs) ? wb_data : rf_q[rs];
  assign rt_val = (rt == 5'd0) ? '0 : (wb_fwd && wb_addr == rt) ? wb_data : rf_q[rt];
  assign rd_val = (rd == 5'd0) ? '0 : (wb_fwd && wb_addr == rd) ? wb_data : rf_q[rd];

  always_comb begin
    dec           = '0;
    dec_ok        = 1'b0;
    use_rs        = 1'b0;
    use_rt        = 1'b0;
    use_rd        = 1'b0;
    dec.valid     = 1'b1;
    dec.read_reg1 = rs_val;
    dec.read_reg2 = rt_val;
    dec.dest_reg  = rd_val;
    dec.imm       = {{16{if_instr[15]}}, if_instr[15:0]};
    dec.pc        = if_pc + 32'd4;
    case (op)
      OpRtype: begin
        dec_ok        = 1'b1;
        use_rs        = 1'b1;
        use_rt        = 1'b1;
        dec.reg_write = 1'b1;
        dec.wr_addr   = rd;
        case (funct)
          6'b100000: dec.alu_ctrl = 3'b000;
          6'b100010: dec.alu_ctrl = 3'b001;
          6'b000100: dec.alu_ctrl = 3'b010;
          6'b000111: dec.alu_ctrl = 3'b011;
          6'b100100: dec.alu_ctrl = 3'b100;
          6'b100101: dec.alu_ctrl = 3'b101;
          default:   dec_ok       = 1'b0;
        endcase
      end
      OpAddi: begin
        dec_ok        = 1'b1;
        use_rs        = 1'b1;
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        dec.wr_addr   = rt;
      end
      OpLw: begin
        dec_ok        = 1'b1;
        use_rs        = 1'b1;
        dec.alu_src   = 1'b1;
        dec.mem_read  = 1'b1;
        dec.reg_write = 1'b1;
        dec.wr_addr   = rt;
      end
      OpSw: begin
        dec_ok        = 1'b1;
        use_rs        = 1'b1;
        use_rt        = 1'b1;
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
      end
      OpBeq: begin
        dec_ok       = 1'b1;
        use_rs       = 1'b1;
        use_rt       = 1'b1;
        dec.alu_ctrl = 3'b001;
        dec.branch   = 1'b1;
      end
      OpMac: begin
        dec_ok        = 1'b1;
        use_rs        = 1'b1;
        use_rt        = 1'b1;
        use_rd        = 1'b1;
        dec.mac       = 1'b1;
        dec.reg_write = 1'b1;
        dec.wr_addr   = rd;
      end
      default: dec_ok = 1'b0;
    endcase
    // Bubbles read nothing, so they can never cause a stall.
    if (!(dec_ok && if_valid)) begin
      dec_ok = 1'b0;
      use_rs = 1'b0;
      use_rt = 1'b0;
      use_rd = 1'b0;
    end
  end

  assign ld_pending = idex_q.valid & idex_q.mem_read & (idex_q.wr_addr != 5'd0);
  assign hazard     = ld_pending & ((use_rs & (rs == idex_q.wr_addr)) |
                                    (use_rt & (rt == idex_q.wr_addr)) |
                                    (use_rd & (rd == idex_q.wr_addr)));
  // A taken branch redirects fetch, so a stall request would be meaningless.
  assign id_stall   = hazard & ~pcsrc;
  assign idex_d     = (dec_ok && !pcsrc && !hazard) ? dec : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) idex_q <= '0;
    else     idex_q <= idex_d;
  end

  assign ex_valid     = idex_q.valid;
  assign ex_read_reg1 = idex_q.read_reg1;
  assign ex_read_reg2 = idex_q.read_reg2;
  assign ex_dest_reg  = idex_q.dest_reg;
  assign ex_imm       = idex_q.imm;
  assign ex_pc        = idex_q.pc;
  assign ex_alu_src   = idex_q.alu_src;
  assign ex_alu_ctrl  = idex_q.alu_ctrl;
  assign ex_branch    = idex_q.branch;
  assign ex_mac       = idex_q.mac;
  assign ex_mem_read  = idex_q.mem_read;
  assign ex_mem_write = idex_q.mem_write;
  assign ex_reg_write = idex_q.reg_write;
  assign ex_wr_addr   = idex_q.wr_addr;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios then random instruction streams, all checked
// against an instruction-level reference model of decode, register file and load-use rules.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] if_instr, if_pc, wb_data;
  logic        if_valid, pcsrc, wb_we;
  logic [4:0]  wb_addr;
  logic        id_stall;
  logic [31:0] ex_read_reg1, ex_read_reg2, ex_dest_reg, ex_imm, ex_pc;
  logic        ex_alu_src, ex_branch, ex_mac, ex_mem_read, ex_mem_write, ex_reg_write, ex_valid;
  logic [2:0]  ex_alu_ctrl;
  logic [4:0]  ex_wr_addr;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk          (clk),
    .rst          (rst),
    .if_instr     (if_instr),
    .if_pc        (if_pc),
    .if_valid     (if_valid),
    .pcsrc        (pcsrc),
    .wb_we        (wb_we),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .id_stall     (id_stall),
    .ex_read_reg1 (ex_read_reg1),
    .ex_read_reg2 (ex_read_reg2),
    .ex_dest_reg  (ex_dest_reg),
    .ex_imm       (ex_imm),
    .ex_pc        (ex_pc),
    .ex_alu_src   (ex_alu_src),
    .ex_alu_ctrl  (ex_alu_ctrl),
    .ex_branch    (ex_branch),
    .ex_mac       (ex_mac),
    .ex_mem_read  (ex_mem_read),
    .ex_mem_write (ex_mem_write),
    .ex_reg_write (ex_reg_write),
    .ex_wr_addr   (ex_wr_addr),
    .ex_valid     (ex_valid)
  );

  typedef struct packed {
    logic        valid;
    logic [31:0] r1, r2, rd, imm, pc;
    logic        alu_src;
    logic [2:0]  ctrl;
    logic        branch, mac, mrd, mwr, rw;
    logic [4:0]  wa;
  } ex_t;

  ex_t got;
  assign got = {ex_valid, ex_read_reg1, ex_read_reg2, ex_dest_reg, ex_imm, ex_pc, ex_alu_src,
                ex_alu_ctrl, ex_branch, ex_mac, ex_mem_read, ex_mem_write, ex_reg_write,
                ex_wr_addr};

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] m_rf [32];
  ex_t         m_ex;
  logic        s;

  task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [31:0] rdreg(input logic [4:0] i);
    if (i == 5'd0) return 32'd0;
    if (wb_we && wb_addr == i) return wb_data;
    return m_rf[i];
  endfunction

  // Reference: what the ISA says this instruction means, plus the load-use rule.
  task automatic model(output ex_t nxt, output logic hz);
    logic [5:0] op, fn;
    logic [4:0] rs, rt, rd;
    logic ok, urs, urt, urd;
    ex_t e;
    op = if_instr[31:26]; fn = if_instr[5:0];
    rs = if_instr[25:21]; rt = if_instr[20:16]; rd = if_instr[15:11];
    e = '0; ok = 1'b1; urs = 1'b1; urt = 1'b0; urd = 1'b0;
    case (op)
      6'd0: begin
        e.rw = 1; e.wa = rd; urt = 1;
        case (fn)
          6'h20: e.ctrl = 0;
          6'h22: e.ctrl = 1;
          6'h04: e.ctrl = 2;
          6'h07: e.ctrl = 3;
          6'h24: e.ctrl = 4;
          6'h25: e.ctrl = 5;
          default: ok = 0;
        endcase
      end
      6'h08: begin e.alu_src = 1; e.rw = 1; e.wa = rt; end
      6'h23: begin e.alu_src = 1; e.rw = 1; e.wa = rt; e.mrd = 1; end
      6'h2B: begin e.alu_src = 1; e.mwr = 1; urt = 1; end
      6'h04: begin e.ctrl = 1; e.branch = 1; urt = 1; end
      6'h1C: begin e.mac = 1; e.rw = 1; e.wa = rd; urt = 1; urd = 1; end
      default: ok = 0;
    endcase
    ok = ok && if_valid;
    e.valid = 1; e.r1 = rdreg(rs); e.r2 = rdreg(rt); e.rd = rdreg(rd);
    e.imm = {{16{if_instr[15]}}, if_instr[15:0]};
    e.pc = if_pc + 4;
    hz = ok && m_ex.valid && m_ex.mrd && m_ex.wa != 0 &&
         ((urs && rs == m_ex.wa) || (urt && rt == m_ex.wa) || (urd && rd == m_ex.wa));
    nxt = (ok && !pcsrc && !hz) ? e : '0;
  endtask

  // Called at posedge+1; checks id_stall mid-cycle and ex_* after the next edge.
  task automatic step(input logic [31:0] ins, input logic [31:0] pc, input logic v,
                      input logic ps, input logic we, input logic [4:0] wa,
                      input logic [31:0] wd, output logic stall_seen);
    ex_t nxt;
    logic hz;
    if_instr = ins; if_pc = pc; if_valid = v; pcsrc = ps;
    wb_we = we; wb_addr = wa; wb_data = wd;
    #4;
    model(nxt, hz);
    stall_seen = id_stall;
    chk("id_stall", {199'd0, id_stall}, {199'd0, hz && !ps});
    if (we && wa != 0) m_rf[wa] = wd;
    m_ex = nxt;
    @(posedge clk);
    #1;
    chk("ex_bundle", got, m_ex);
  endtask

  task automatic wb(input logic [4:0] wa, input logic [31:0] wd);
    step(32'd0, 32'd0, 1'b0, 1'b0, 1'b1, wa, wd, s);
  endtask

  initial begin
    logic [31:0] ins, prev;
    logic [5:0]  fns [6] = '{6'h20, 6'h22, 6'h04, 6'h07, 6'h24, 6'h25};
    logic [5:0]  ops [6] = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h1C};
    if_instr = '0; if_pc = '0; if_valid = 0; pcsrc = 0; wb_we = 0; wb_addr = '0; wb_data = '0;
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    m_ex = '0;
    #1 rst = 1'b1;
    #1;
    chk("reset_bundle", got, '0);
    chk("reset_stall", {199'd0, id_stall}, '0);
    @(posedge clk);
    #1 rst = 1'b0;

    // add r3,r5,r5 after writing r5=7
    wb(5'd5, 32'd7);
    step(32'h00A51820, 32'h0, 1, 0, 0, 0, 0, s);
    chk("add_r1", ex_read_reg1, 32'd7);
    chk("add_r2", ex_read_reg2, 32'd7);
    chk("add_ctrl", ex_alu_ctrl, 3'b000);
    chk("add_wa", ex_wr_addr, 5'd3);
    chk("add_rw", ex_reg_write, 1'b1);
    chk("add_valid", ex_valid, 1'b1);

    // addi r2,r0,-4 while writing r0; r0 must still read 0
    step(32'h2002FFFC, 32'h4, 1, 0, 1, 5'd0, 32'hFFFF_FFFF, s);
    chk("addi_imm", ex_imm, 32'hFFFF_FFFC);
    chk("addi_src", ex_alu_src, 1'b1);
    chk("addi_wa", ex_wr_addr, 5'd2);
    step(32'h00001820, 32'h8, 1, 0, 0, 0, 0, s);
    chk("r0_read", ex_read_reg1, 32'd0);

    // lw r4,0(r1); add r6,r4,r4 held across the stall
    step(32'h8C240000, 32'hC, 1, 0, 0, 0, 0, s);
    chk("lw_mrd", ex_mem_read, 1'b1);
    step(32'h00843020, 32'h10, 1, 0, 0, 0, 0, s);
    chk("lu_stall1", s, 1'b1);
    chk("lu_bubble", ex_valid, 1'b0);
    step(32'h00843020, 32'h10, 1, 0, 0, 0, 0, s);
    chk("lu_stall2", s, 1'b0);
    chk("lu_issue", ex_valid, 1'b1);
    chk("lu_wa", ex_wr_addr, 5'd6);

    // Load-use coinciding with a taken branch: bubble, no stall
    step(32'h8C240000, 32'h14, 1, 0, 0, 0, 0, s);
    step(32'h00843020, 32'h18, 1, 1, 0, 0, 0, s);
    chk("ps_hz_stall", s, 1'b0);
    chk("ps_hz_bubble", ex_valid, 1'b0);

    // mac r7,r1,r2
    wb(5'd1, 32'd3);
    wb(5'd2, 32'd5);
    wb(5'd7, 32'd10);
    step(32'h70223800, 32'h20, 1, 0, 0, 0, 0, s);
    chk("mac_flag", ex_mac, 1'b1);
    chk("mac_r1", ex_read_reg1, 32'd3);
    chk("mac_r2", ex_read_reg2, 32'd5);
    chk("mac_dest", ex_dest_reg, 32'd10);
    chk("mac_wa", ex_wr_addr, 5'd7);

    // beq at 0x40, then pcsrc flushes the next one
    step(32'h10220000, 32'h40, 1, 0, 0, 0, 0, s);
    chk("beq_branch", ex_branch, 1'b1);
    chk("beq_ctrl", ex_alu_ctrl, 3'b001);
    chk("beq_pc", ex_pc, 32'h44);
    step(32'h00A51820, 32'h44, 1, 1, 0, 0, 0, s);
    chk("flush_bubble", got, '0);

    // Same-cycle bypass: or r1,r9,r0 while writing r9
    step(32'h01200825, 32'h48, 1, 0, 1, 5'd9, 32'h1234, s);
    chk("bypass_r1", ex_read_reg1, 32'h1234);

    // Asynchronous reset mid-stream
    #2 rst = 1'b1;
    #1;
    chk("async_bundle", got, '0);
    chk("async_stall", {199'd0, id_stall}, '0);
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    m_ex = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    step(32'h01200825, 32'h4C, 1, 0, 0, 0, 0, s);
    chk("rf_cleared", ex_read_reg1, 32'd0);

    // Random streams over a small register window to provoke hazards and bypasses
    prev = 32'h00A51820;
    for (int n = 0; n < 400; n++) begin
      int k;
      k = $urandom_range(0, 9);
      if (k == 9) ins = prev;
      else if (k == 8) ins = $urandom;
      else begin
        ins = $urandom;
        ins[31:26] = ops[k % 6];
        ins[25:21] = 5'($urandom_range(0, 7));
        ins[20:16] = 5'($urandom_range(0, 7));
        ins[15:11] = 5'($urandom_range(0, 7));
        if (ins[31:26] == 6'd0) ins[5:0] = ($urandom_range(0, 9) == 0) ? 6'h3F
                                                                      : fns[$urandom_range(0, 5)];
      end
      prev = ins;
      step(ins, $urandom, ($urandom_range(0, 7) != 0), ($urandom_range(0, 5) == 0),
           1'($urandom), 5'($urandom_range(0, 7)), $urandom, s);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction-decode stage and ID/EX pipeline register that produces every operand and control input consumed by the execute (ALU/MAC) stage. It holds the 32x32 register file and receives the writeback port. It decodes the 32-bit instruction into ALU/MAC/branch/memory controls and detects load-use hazards. It registers the result into the ID/EX boundary, inserting bubbles on stall and on branch-taken flush.

## Interface
Parameters: none (fixed 32-bit datapath, 32 registers).
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- if_instr  in  32  instruction from IF/ID register
- if_pc  in  32  address of if_instr
- if_valid  in  1  if_instr is a real instruction
- pcsrc  in  1  branch taken, from execute stage; flushes ID/EX
- wb_we  in  1  register-file write enable from writeback
- wb_addr  in  5  writeback register index
- wb_data  in  32  writeback data
- id_stall  out  1  combinational; fetch must hold PC and IF/ID this cycle
- ex_read_reg1 / ex_read_reg2  out  32  rs / rt operand values
- ex_dest_reg  out  32  rd value (MAC accumulator input)
- ex_imm  out  32  sign-extended instr[15:0]
- ex_pc  out  32  if_pc + 4
- ex_alu_src  out  1  1 = immediate as ALU operand B
- ex_alu_ctrl  out  3  000 add, 001 sub, 010 shl, 011 sra, 100 and, 101 or
- ex_branch, ex_mac, ex_mem_read, ex_mem_write, ex_reg_write  out  1 each
- ex_wr_addr  out  5  destination register index
- ex_valid  out  1  ID/EX holds a real instruction

## Operation
- Fields: op=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], funct=[5:0], imm=[15:0] sign-extended.
- op 000000 R-type, write rd, alu_src 0. The funct field maps as follows: 100000 add→000, 100010 sub→001, 000100 shl→010, 000111 sra→011, 100100 and→100, 100101 or→101.
- op 001000 addi: ctrl 000, alu_src 1, write rt.
- op 100011 lw: ctrl 000, alu_src 1, mem_read, write rt.
- op 101011 sw: ctrl 000, alu_src 1, mem_write, no write.
- op 000100 beq: ctrl 001, alu_src 0, branch, no write.
- op 011100 mac: mac 1, alu_src 0, write rd. It reads rs, rt and rd (rd value on ex_dest_reg).
- Unknown op or funct, or if_valid=0: decoded as bubble.
- Register file:
  - Register 0 reads 0 and ignores writes.
  - Writes occur at posedge when wb_we=1 and wb_addr≠0.
  - Read bypass: if wb_we=1, wb_addr≠0 and wb_addr equals the read index, the read returns wb_data in the same cycle.
- ex_dest_reg always carries rf[rd] (bypassed), including for non-MAC instructions.
- Load-use hazard:
  - The hazard is raised when ex_valid & ex_mem_read & ex_wr_addr≠0 and ex_wr_addr matches a source this instruction uses. Sources are rs for all valid ops except none; rt for R-type, beq, sw and mac; rd for mac.
  - On a hazard, id_stall=1 and a bubble is written to ID/EX.
- Bubble: ex_valid=0 and every ex_* output is 0.
- Priority at posedge: rst > pcsrc (bubble, id_stall ignored by fetch since it redirects) > hazard (bubble) > decoded instruction.
- id_stall is forced 0 while pcsrc=1.

## Timing
- Reset: every ex_* output is 0, all 32 registers are 0, and id_stall=0 (given that ex_valid=0).
- Reset asserted mid-operation clears ID/EX and the register file immediately, without waiting for clk.
- Latency is 1 cycle: an instruction presented in cycle N appears on ex_* in cycle N+1.
- Stall: id_stall rises in the same cycle the hazard exists. With if_instr held, it drops the next cycle once the load has left ID/EX, and the instruction is then issued. A load-use therefore costs exactly one bubble.
- A writeback in cycle N is visible to a decode in cycle N via the bypass.
- Simultaneous pcsrc and hazard: a bubble is issued and id_stall=0.

## Test plan
- Reset then write r5=0x0000_0007 via wb. The next cycle decodes "add r3,r5,r5" (0x00A51820). Required: ex_read_reg1=ex_read_reg2=7, ex_alu_ctrl=000, ex_wr_addr=3, ex_reg_write=1, ex_valid=1.
- addi r2,r0,-4 (0x2002FFFC): ex_imm=0xFFFF_FFFC, ex_alu_src=1, ex_wr_addr=2. Also apply wb_we=1, wb_addr=0, wb_data=0xFFFF_FFFF; a later read of r0 returns 0.
- lw r4,0(r1) followed by add r6,r4,r4: id_stall=1 for exactly one cycle, one bubble (ex_valid=0) is issued, then the add issues with ex_valid=1.
- mac r7,r1,r2 with r1=3, r2=5, r7=10: ex_mac=1, ex_read_reg1=3, ex_read_reg2=5, ex_dest_reg=10, ex_wr_addr=7.
- beq at if_pc=0x40 followed by pcsrc=1 in the next cycle: the first ex_* shows ex_branch=1, ex_alu_ctrl=001 and ex_pc=0x44. The following cycle is a bubble regardless of if_instr.
- Same-cycle bypass: wb writes r9=0x1234 while decoding "or r1,r9,r0". Required: ex_read_reg1=0x1234. Additionally, asserting rst mid-stream zeroes all outputs asynchronously.
